// File: rtl/rv32i_multicycle_sequencer_if.sv
// Instruction/data memory handshake bundle between the multicycle sequencer
// (master) and the memory side (slave).
interface rv32i_multicycle_sequencer_if;
   logic imem_req;
   logic imem_ack;
   logic dmem_req;
   logic dmem_ack;
   logic mem_read;
   logic mem_write;

   modport master (
      output imem_req,
      output dmem_req,
      output mem_read,
      output mem_write,
      input  imem_ack,
      input  dmem_ack
   );

   modport slave (
      input  imem_req,
      input  dmem_req,
      input  mem_read,
      input  mem_write,
      output imem_ack,
      output dmem_ack
   );
endinterface

// File: rtl/rv32i_multicycle_sequencer.sv
// Multi-cycle RV32I control sequencer: walks each instruction through
// fetch/decode/execute/memory/writeback and parks in a sticky trap on faults.
module rv32i_multicycle_sequencer #(
   parameter int         MEM_TIMEOUT  = 16,
   parameter logic [1:0] RESET_PC_SEL = 2'b11
) (
   input  logic                                clk,
   input  logic                                reset_n,
   rv32i_multicycle_sequencer_if.master        bus,
   input  logic [6:0]                          opcode,
   input  logic [2:0]                          funct3,
   input  logic                                alu_zero,
   input  logic                                alu_lt,
   input  logic                                alu_ltu,
   output logic                                ir_write,
   output logic                                pc_write,
   output logic [1:0]                          pc_src,
   output logic                                reg_write,
   output logic                                alu_src,
   output logic [1:0]                          alu_op,
   output logic [1:0]                          wb_sel,
   output logic                                trap,
   output logic [1:0]                          trap_cause,
   output logic [2:0]                          state
);

   typedef enum logic [2:0] {
      S_FETCH  = 3'd0,
      S_DECODE = 3'd1,
      S_EXEC   = 3'd2,
      S_MEM    = 3'd3,
      S_WB     = 3'd4,
      S_TRAP   = 3'd7
   } state_t;

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [1:0] PC_PLUS4  = 2'b00;
   localparam logic [1:0] PC_TARGET = 2'b01;
   localparam logic [1:0] PC_JALR   = 2'b10;

   localparam logic [1:0] ALU_ARITH = 2'b00;
   localparam logic [1:0] ALU_CMP   = 2'b01;
   localparam logic [1:0] ALU_ADD   = 2'b10;

   localparam logic [1:0] WB_ALU    = 2'b00;
   localparam logic [1:0] WB_MEM    = 2'b01;
   localparam logic [1:0] WB_LINK   = 2'b10;
   localparam logic [1:0] WB_IMM    = 2'b11;

   localparam logic [1:0] CAUSE_NONE    = 2'b00;
   localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
   localparam logic [1:0] CAUSE_IMEM    = 2'b10;
   localparam logic [1:0] CAUSE_DMEM    = 2'b11;

   // The last waiting cycle is the one whose counter equals MEM_TIMEOUT-1;
   // an ack there still succeeds, silence there traps.
   localparam logic [7:0] TIMEOUT_LAST = 8'(MEM_TIMEOUT - 1);

   state_t     state_q;
   state_t     state_next;
   logic [7:0] count_q;
   logic [7:0] count_next;
   logic [1:0] cause_q;
   logic [1:0] cause_next;
   logic       reset_hold;
   logic       boot_pending;

   logic       opcode_legal;
   logic       branch_taken;
   logic       branch_bad_funct3;
   logic       imem_req_c;
   logic       dmem_req_c;
   logic       mem_read_c;
   logic       mem_write_c;

   // reset_hold keeps every output quiet while reset is applied; boot_pending
   // then marks the single boot-vector cycle right after release.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q      <= S_FETCH;
         count_q      <= '0;
         cause_q      <= CAUSE_NONE;
         reset_hold   <= 1'b1;
         boot_pending <= 1'b0;
      end else begin
         state_q      <= state_next;
         count_q      <= count_next;
         cause_q      <= cause_next;
         reset_hold   <= 1'b0;
         boot_pending <= reset_hold;
      end
   end

   assign opcode_legal = opcode inside {OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH,
                                        OP_LUI, OP_AUIPC, OP_JAL, OP_JALR};

   assign branch_bad_funct3 = (funct3 == 3'b010) || (funct3 == 3'b011);

   always_comb begin
      branch_taken = 1'b0;
      case (funct3)
         3'b000:  branch_taken = alu_zero;
         3'b001:  branch_taken = !alu_zero;
         3'b100:  branch_taken = alu_lt;
         3'b101:  branch_taken = !alu_lt;
         3'b110:  branch_taken = alu_ltu;
         3'b111:  branch_taken = !alu_ltu;
         default: branch_taken = 1'b0;
      endcase
   end

   // Next-state and per-cycle datapath controls; everything defaults low so
   // each enable only appears in the state that owns it.
   always_comb begin
      state_next  = state_q;
      count_next  = count_q;
      cause_next  = cause_q;
      imem_req_c  = 1'b0;
      dmem_req_c  = 1'b0;
      mem_read_c  = 1'b0;
      mem_write_c = 1'b0;
      ir_write    = 1'b0;
      pc_write    = 1'b0;
      pc_src      = PC_PLUS4;
      reg_write   = 1'b0;
      alu_src     = 1'b0;
      alu_op      = ALU_ARITH;
      wb_sel      = WB_ALU;
      trap        = 1'b0;

      if (!reset_hold) begin
         case (state_q)
            S_FETCH: begin
               if (boot_pending) begin
                  pc_write = 1'b1;
                  pc_src   = RESET_PC_SEL;
               end else begin
                  imem_req_c = 1'b1;
                  if (bus.imem_ack) begin
                     ir_write   = 1'b1;
                     pc_write   = 1'b1;
                     pc_src     = PC_PLUS4;
                     state_next = S_DECODE;
                     count_next = '0;
                  end else if (count_q == TIMEOUT_LAST) begin
                     state_next = S_TRAP;
                     cause_next = CAUSE_IMEM;
                     count_next = '0;
                  end else begin
                     count_next = count_q + 8'd1;
                  end
               end
            end

            S_DECODE: begin
               if (opcode_legal) begin
                  state_next = S_EXEC;
               end else begin
                  state_next = S_TRAP;
                  cause_next = CAUSE_ILLEGAL;
               end
            end

            S_EXEC: begin
               case (opcode)
                  OP_R: begin
                     state_next = S_WB;
                  end
                  OP_I: begin
                     alu_src    = 1'b1;
                     state_next = S_WB;
                  end
                  OP_LOAD, OP_STORE: begin
                     alu_src    = 1'b1;
                     alu_op     = ALU_ADD;
                     state_next = S_MEM;
                  end
                  OP_BRANCH: begin
                     alu_op = ALU_CMP;
                     if (branch_bad_funct3) begin
                        state_next = S_TRAP;
                        cause_next = CAUSE_ILLEGAL;
                     end else begin
                        pc_write   = branch_taken;
                        pc_src     = branch_taken ? PC_TARGET : PC_PLUS4;
                        state_next = S_FETCH;
                     end
                  end
                  OP_JAL: begin
                     pc_write   = 1'b1;
                     pc_src     = PC_TARGET;
                     state_next = S_WB;
                  end
                  OP_JALR: begin
                     pc_write   = 1'b1;
                     pc_src     = PC_JALR;
                     state_next = S_WB;
                  end
                  OP_LUI, OP_AUIPC: begin
                     alu_src    = 1'b1;
                     alu_op     = ALU_ADD;
                     state_next = S_WB;
                  end
                  default: begin
                     state_next = S_TRAP;
                     cause_next = CAUSE_ILLEGAL;
                  end
               endcase
            end

            S_MEM: begin
               dmem_req_c  = 1'b1;
               mem_read_c  = (opcode == OP_LOAD);
               mem_write_c = (opcode == OP_STORE);
               if (bus.dmem_ack) begin
                  state_next = (opcode == OP_LOAD) ? S_WB : S_FETCH;
                  count_next = '0;
               end else if (count_q == TIMEOUT_LAST) begin
                  state_next = S_TRAP;
                  cause_next = CAUSE_DMEM;
                  count_next = '0;
               end else begin
                  count_next = count_q + 8'd1;
               end
            end

            S_WB: begin
               reg_write = 1'b1;
               case (opcode)
                  OP_LOAD:          wb_sel = WB_MEM;
                  OP_JAL, OP_JALR:  wb_sel = WB_LINK;
                  OP_LUI:           wb_sel = WB_IMM;
                  default:          wb_sel = WB_ALU;
               endcase
               state_next = S_FETCH;
            end

            S_TRAP: begin
               trap = 1'b1;
            end

            default: begin
               state_next = S_FETCH;
               count_next = '0;
            end
         endcase
      end
   end

   assign bus.imem_req  = imem_req_c;
   assign bus.dmem_req  = dmem_req_c;
   assign bus.mem_read  = mem_read_c;
   assign bus.mem_write = mem_write_c;
   assign trap_cause    = cause_q;
   assign state         = state_q;

endmodule

// File: tb/tb_rv32i_multicycle_sequencer.sv
// Self-checking bench for rv32i_multicycle_sequencer: a trace-level model
// predicts every cycle's outputs for each instruction, plus table outcomes.
module tb_rv32i_multicycle_sequencer;

   localparam int TO = 16;

   typedef struct packed {
      logic [2:0] state;
      logic       imem_req;
      logic       ir_write;
      logic       pc_write;
      logic [1:0] pc_src;
      logic       dmem_req;
      logic       mem_read;
      logic       mem_write;
      logic       reg_write;
      logic       alu_src;
      logic [1:0] alu_op;
      logic [1:0] wb_sel;
      logic       trap;
      logic [1:0] trap_cause;
   } outs_t;

   typedef struct {
      logic  imem_ack;
      logic  dmem_ack;
      outs_t exp;
   } cyc_t;

   typedef struct {
      logic [6:0] op;
      logic [2:0] f3;
      logic       z;
      logic       lt;
      logic       ltu;
      int         iwait;
      int         dwait;
      int         len;
      int         pcw;
      int         wb;
      int         cause;
   } vec_t;

   logic       clk = 1'b0;
   logic       reset_n = 1'b0;
   logic [6:0] opcode = '0;
   logic [2:0] funct3 = '0;
   logic       alu_zero = 1'b0;
   logic       alu_lt = 1'b0;
   logic       alu_ltu = 1'b0;
   logic       ir_write;
   logic       pc_write;
   logic [1:0] pc_src;
   logic       reg_write;
   logic       alu_src;
   logic [1:0] alu_op;
   logic [1:0] wb_sel;
   logic       trap;
   logic [1:0] trap_cause;
   logic [2:0] state;

   rv32i_multicycle_sequencer_if bus();

   rv32i_multicycle_sequencer #(
      .MEM_TIMEOUT  (TO),
      .RESET_PC_SEL (2'b11)
   ) dut (
      .clk        (clk),
      .reset_n    (reset_n),
      .bus        (bus),
      .opcode     (opcode),
      .funct3     (funct3),
      .alu_zero   (alu_zero),
      .alu_lt     (alu_lt),
      .alu_ltu    (alu_ltu),
      .ir_write   (ir_write),
      .pc_write   (pc_write),
      .pc_src     (pc_src),
      .reg_write  (reg_write),
      .alu_src    (alu_src),
      .alu_op     (alu_op),
      .wb_sel     (wb_sel),
      .trap       (trap),
      .trap_cause (trap_cause),
      .state      (state)
   );

   always #5 clk = ~clk;

   int         checks = 0;
   int         fails = 0;
   cyc_t       plan[$];
   vec_t       vecs[19];
   logic [6:0] cur_op;
   logic [2:0] cur_f3;
   logic       cur_z;
   logic       cur_lt;
   logic       cur_ltu;
   int         obs_len;
   int         obs_pcw;
   int         obs_wb;
   int         obs_cause;

   function automatic cyc_t mk(logic [2:0] st, bit noisy);
      cyc_t c;
      c.exp       = '0;
      c.exp.state = st;
      c.imem_ack  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      c.dmem_ack  = noisy ? 1'($urandom_range(0, 1)) : 1'b0;
      return c;
   endfunction

   function automatic void addTrap(logic [1:0] cause, int n);
      cyc_t c;
      for (int i = 0; i < n; i++) begin
         c = mk(3'd7, 1'b1);
         c.exp.trap       = 1'b1;
         c.exp.trap_cause = cause;
         plan.push_back(c);
      end
   endfunction

   // Builds the expected cycle trace of one instruction from the ISA-level
   // rules: fetch wait, one decode cycle, execute, optional memory, writeback.
   function automatic void buildPlan(logic [6:0] op, logic [2:0] f3, logic z, logic lt,
                                     logic ltu, int iwait, int dwait, int ntrap);
      logic [6:0] legal_ops[9] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                                   7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                                   7'b1100111};
      logic [7:0] cond;
      bit         legal = 1'b0;
      bit         is_load = (op == 7'b0000011);
      bit         is_store = (op == 7'b0100011);
      cyc_t       c;
      plan.delete();
      for (int i = 0; i < iwait && i < TO; i++) begin
         c = mk(3'd0, 1'b1);
         c.imem_ack = 1'b0;
         c.exp.imem_req = 1'b1;
         plan.push_back(c);
      end
      if (iwait >= TO) begin
         addTrap(2'b10, ntrap);
         return;
      end
      c = mk(3'd0, 1'b0);
      c.imem_ack = 1'b1;
      c.exp.imem_req = 1'b1;
      c.exp.ir_write = 1'b1;
      c.exp.pc_write = 1'b1;
      plan.push_back(c);
      plan.push_back(mk(3'd1, 1'b1));
      foreach (legal_ops[i]) if (legal_ops[i] == op) legal = 1'b1;
      if (!legal) begin
         addTrap(2'b01, ntrap);
         return;
      end
      c = mk(3'd2, 1'b1);
      if (op == 7'b1100011) begin
         c.exp.alu_op = 2'b01;
         if (f3 == 3'd2 || f3 == 3'd3) begin
            plan.push_back(c);
            addTrap(2'b01, ntrap);
            return;
         end
         cond = {!ltu, ltu, !lt, lt, 1'b0, 1'b0, !z, z};
         if (cond[f3]) begin
            c.exp.pc_write = 1'b1;
            c.exp.pc_src   = 2'b01;
         end
         plan.push_back(c);
         return;
      end
      if (op == 7'b0010011) c.exp.alu_src = 1'b1;
      if (is_load || is_store || op == 7'b0110111 || op == 7'b0010111) begin
         c.exp.alu_src = 1'b1;
         c.exp.alu_op  = 2'b10;
      end
      if (op == 7'b1101111 || op == 7'b1100111) begin
         c.exp.pc_write = 1'b1;
         c.exp.pc_src   = (op == 7'b1101111) ? 2'b01 : 2'b10;
      end
      plan.push_back(c);
      if (is_load || is_store) begin
         for (int i = 0; i <= dwait && i < TO; i++) begin
            c = mk(3'd3, 1'b1);
            c.dmem_ack = (i == dwait);
            c.exp.dmem_req  = 1'b1;
            c.exp.mem_read  = is_load;
            c.exp.mem_write = is_store;
            plan.push_back(c);
         end
         if (dwait >= TO) begin
            addTrap(2'b11, ntrap);
            return;
         end
         if (is_store) return;
      end
      c = mk(3'd4, 1'b1);
      c.exp.reg_write = 1'b1;
      if (is_load)                                   c.exp.wb_sel = 2'b01;
      else if (op == 7'b1101111 || op == 7'b1100111) c.exp.wb_sel = 2'b10;
      else if (op == 7'b0110111)                     c.exp.wb_sel = 2'b11;
      plan.push_back(c);
   endfunction

   task automatic applyStimulus(cyc_t c);
      @(negedge clk);
      opcode       = cur_op;
      funct3       = cur_f3;
      alu_zero     = cur_z;
      alu_lt       = cur_lt;
      alu_ltu      = cur_ltu;
      bus.imem_ack = c.imem_ack;
      bus.dmem_ack = c.dmem_ack;
      #1;
   endtask

   task automatic checkOutput(outs_t want, string name, int idx);
      outs_t got;
      got.state      = state;
      got.imem_req   = bus.imem_req;
      got.ir_write   = ir_write;
      got.pc_write   = pc_write;
      got.pc_src     = pc_src;
      got.dmem_req   = bus.dmem_req;
      got.mem_read   = bus.mem_read;
      got.mem_write  = bus.mem_write;
      got.reg_write  = reg_write;
      got.alu_src    = alu_src;
      got.alu_op     = alu_op;
      got.wb_sel     = wb_sel;
      got.trap       = trap;
      got.trap_cause = trap_cause;
      checks++;
      if (got !== want) begin
         fails++;
         $display("[TB] FAIL %s cycle %0d: outputs got %05h want %05h (state got %0d want %0d)",
                  name, idx, got, want, got.state, want.state);
      end
   endtask

   task automatic checkValue(string name, int got, int want);
      checks++;
      if (got != want) begin
         fails++;
         $display("[TB] FAIL %s: got %0d want %0d", name, got, want);
      end
   endtask

   task automatic runPlan(string name, int limit);
      bit left = 1'b0;
      bit done = 1'b0;
      obs_len   = 0;
      obs_pcw   = 0;
      obs_wb    = -1;
      obs_cause = 0;
      for (int i = 0; i < plan.size() && i < limit; i++) begin
         applyStimulus(plan[i]);
         checkOutput(plan[i].exp, name, i);
         if (!done) begin
            if (state == 3'd7 || (left && state == 3'd0)) done = 1'b1;
            else begin
               obs_len++;
               if (state != 3'd0) left = 1'b1;
            end
         end
         if (state == 3'd2 && pc_write) obs_pcw = 1;
         if (reg_write) obs_wb = int'(wb_sel);
         obs_cause = int'(trap_cause);
      end
   endtask

   task automatic doReset(string name);
      outs_t exp;
      @(negedge clk);
      reset_n = 1'b0;
      @(negedge clk);
      #1;
      checkOutput('0, {name, "_reset"}, 0);
      reset_n      = 1'b1;
      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      @(negedge clk);
      #1;
      exp          = '0;
      exp.pc_write = 1'b1;
      exp.pc_src   = 2'b11;
      checkOutput(exp, {name, "_boot"}, 0);
   endtask

   task automatic setInstr(logic [6:0] op, logic [2:0] f3, logic z, logic lt, logic ltu);
      cur_op  = op;
      cur_f3  = f3;
      cur_z   = z;
      cur_lt  = lt;
      cur_ltu = ltu;
   endtask

   initial begin
      #10_000_000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      string nm;
      logic [6:0] rops[10] = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011,
                               7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111,
                               7'b1100111, 7'b1111111};

      //           op          f3    z     lt    ltu   iw  dw  len pcw wb cause
      vecs[0]  = '{7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 0,  0,  4,  0,  0, 0};
      vecs[1]  = '{7'b0010011, 3'd0, 1'b0, 1'b0, 1'b0, 2,  0,  6,  0,  0, 0};
      vecs[2]  = '{7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0,  3,  8,  0,  1, 0};
      vecs[3]  = '{7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 0,  0,  4,  0, -1, 0};
      vecs[4]  = '{7'b1100011, 3'd0, 1'b1, 1'b0, 1'b0, 0,  0,  3,  1, -1, 0};
      vecs[5]  = '{7'b1100011, 3'd1, 1'b1, 1'b0, 1'b0, 0,  0,  3,  0, -1, 0};
      vecs[6]  = '{7'b1100011, 3'd4, 1'b0, 1'b1, 1'b0, 0,  0,  3,  1, -1, 0};
      vecs[7]  = '{7'b1100011, 3'd7, 1'b0, 1'b0, 1'b1, 0,  0,  3,  0, -1, 0};
      vecs[8]  = '{7'b1100011, 3'd6, 1'b0, 1'b0, 1'b1, 0,  0,  3,  1, -1, 0};
      vecs[9]  = '{7'b1100011, 3'd5, 1'b0, 1'b0, 1'b0, 0,  0,  3,  1, -1, 0};
      vecs[10] = '{7'b0110111, 3'd0, 1'b0, 1'b0, 1'b0, 0,  0,  4,  0,  3, 0};
      vecs[11] = '{7'b0010111, 3'd0, 1'b0, 1'b0, 1'b0, 0,  0,  4,  0,  0, 0};
      vecs[12] = '{7'b1101111, 3'd0, 1'b0, 1'b0, 1'b0, 0,  0,  4,  1,  2, 0};
      vecs[13] = '{7'b1100111, 3'd0, 1'b0, 1'b0, 1'b0, 0,  0,  4,  1,  2, 0};
      vecs[14] = '{7'b0000011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 15, 20,  0,  1, 0};
      vecs[15] = '{7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 15, 0, 19,  0,  0, 0};
      vecs[16] = '{7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 0,  0,  2,  0, -1, 1};
      vecs[17] = '{7'b1100011, 3'd2, 1'b1, 1'b0, 1'b0, 0,  0,  3,  0, -1, 1};
      vecs[18] = '{7'b0110011, 3'd0, 1'b0, 1'b0, 1'b0, 16, 0, 16,  0, -1, 2};

      bus.imem_ack = 1'b0;
      bus.dmem_ack = 1'b0;
      setInstr(7'b0, 3'b0, 1'b0, 1'b0, 1'b0);
      doReset("init");

      foreach (vecs[i]) begin
         nm = $sformatf("vec%0d", i);
         setInstr(vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].lt, vecs[i].ltu);
         buildPlan(vecs[i].op, vecs[i].f3, vecs[i].z, vecs[i].lt, vecs[i].ltu,
                   vecs[i].iwait, vecs[i].dwait, 3);
         runPlan(nm, plan.size());
         checkValue({nm, "_len"}, obs_len, vecs[i].len);
         checkValue({nm, "_exec_pcw"}, obs_pcw, vecs[i].pcw);
         checkValue({nm, "_wb_sel"}, obs_wb, vecs[i].wb);
         checkValue({nm, "_cause"}, obs_cause, vecs[i].cause);
         if (plan[plan.size()-1].exp.state == 3'd7) doReset(nm);
      end

      // Sw with a slow data memory, reset lands in the middle of MEM.
      setInstr(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0);
      buildPlan(7'b0100011, 3'd2, 1'b0, 1'b0, 1'b0, 0, 10, 3);
      runPlan("mid_mem", 5);
      checkValue("mid_mem_req_before_reset", int'(bus.dmem_req), 1);
      doReset("mid_mem");

      // Illegal opcode parks in TRAP for a long stretch, reset clears it.
      setInstr(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0);
      buildPlan(7'b0000000, 3'd0, 1'b0, 1'b0, 1'b0, 0, 0, 20);
      runPlan("illegal_hold", plan.size());
      doReset("illegal_hold");

      // Random instruction stream against the trace model.
      for (int n = 0; n < 60; n++) begin
         logic [6:0] op;
         logic [2:0] f3;
         logic       z;
         logic       lt;
         logic       ltu;
         int         iw;
         int         dw;
         op  = rops[$urandom_range(0, 9)];
         f3  = 3'($urandom_range(0, 7));
         z   = 1'($urandom_range(0, 1));
         lt  = 1'($urandom_range(0, 1));
         ltu = 1'($urandom_range(0, 1));
         iw  = ($urandom_range(0, 12) == 0) ? TO : $urandom_range(0, 3);
         dw  = ($urandom_range(0, 12) == 0) ? TO : $urandom_range(0, 3);
         setInstr(op, f3, z, lt, ltu);
         buildPlan(op, f3, z, lt, ltu, iw, dw, 2);
         nm = $sformatf("rand%0d", n);
         runPlan(nm, plan.size());
         if (plan[plan.size()-1].exp.state == 3'd7) doReset(nm);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
